// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dilithium_pkg
// Description : Shared types and constants for the Dilithium mask generator.
//               Holds the gamma1 mode encoding, per-mode constants and the
//               FSM state encoding used by expand_mask_gen.
// Revision    : 1.0
// ============================================================================
package dilithium_pkg;

  // Runtime gamma1 selection (mode input encoding)
  typedef enum logic {
    GAMMA_2_17 = 1'b0,
    GAMMA_2_19 = 1'b1
  } gamma_mode_t;

  // Per-mode constants
  localparam int GAMMA1_17        = 131072;   // 2^17
  localparam int GAMMA1_19        = 524288;   // 2^19
  localparam int C_BITS_17        = 18;
  localparam int C_BITS_19        = 20;
  localparam int C_BITS_MAX       = 20;
  localparam int SQUEEZE_WORDS_17 = 72;
  localparam int SQUEEZE_WORDS_19 = 80;

  // Absorb framing: 64 seed bytes followed by the 2 nonce bytes
  localparam int ABSORB_WORDS = 9;
  localparam int SEED_BYTES   = 66;
  localparam int NONCE_BITS   = 16;

  // Top-level sequencing states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SPONGE_RST = 3'd1,
    ST_ABSORB     = 3'd2,
    ST_SQUEEZE    = 3'd3,
    ST_NEXT       = 3'd4,
    ST_FINISH     = 3'd5
  } emg_state_t;

  // Coefficient bit width for a given mode
  function automatic int c_bits(gamma_mode_t m);
    return (m == GAMMA_2_17) ? C_BITS_17 : C_BITS_19;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : coeff_unpacker
// Description : Bit accumulator that turns the squeezed SHAKE256 stream into
//               c-bit values z (LSB first) and emits sign_extend(gamma1 - z),
//               one coefficient per cycle. Valid/ready on the input side,
//               valid-only on the output side (the consumer never stalls).
//               Macro EXPAND_MASK_GAMMA17_EN: build both c=18 and c=20 paths
//               and honour mode_i; otherwise c=20 / gamma1=2^19 is fixed.
// Revision    : 1.0
// ============================================================================
module coeff_unpacker
  import dilithium_pkg::*;
#(
  parameter int DATA_OUT_BITS = 64,
  parameter int COEFF_W       = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     mode_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_OUT_BITS-1:0] in_data_i,
  output logic                     out_valid_o,
  output logic [COEFF_W-1:0]       out_data_o
);

  // Worst case: c-1 leftover bits plus one full word
  localparam int ACC_W = DATA_OUT_BITS + C_BITS_MAX - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  // gamma1 - z spans [-gamma1+1, gamma1]; one bit above c holds it signed
  localparam int SUB_W = C_BITS_MAX + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] c_w;
  logic [SUB_W-1:0] gamma_w;
  logic [SUB_W-1:0] z_w;
  logic [SUB_W-1:0] diff_w;

`ifdef EXPAND_MASK_GAMMA17_EN
  assign c_w     = mode_i ? CNT_W'(C_BITS_19) : CNT_W'(C_BITS_17);
  assign gamma_w = mode_i ? SUB_W'(GAMMA1_19) : SUB_W'(GAMMA1_17);
  assign z_w     = mode_i ? SUB_W'(acc_q[C_BITS_19-1:0])
                          : SUB_W'(acc_q[C_BITS_17-1:0]);
`else
  logic unused_mode_i;
  assign unused_mode_i = mode_i;
  assign c_w     = CNT_W'(C_BITS_19);
  assign gamma_w = SUB_W'(GAMMA1_19);
  assign z_w     = SUB_W'(acc_q[C_BITS_19-1:0]);
`endif

  assign diff_w      = gamma_w - z_w;
  assign in_ready_o  = (cnt_q < c_w);
  assign out_valid_o = (cnt_q >= c_w);
  assign out_data_o  = {{(COEFF_W-SUB_W){diff_w[SUB_W-1]}}, diff_w};

  // Append accepted words above the held bits, or retire c bits per coefficient
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid_i && in_ready_o) begin
      acc_d = acc_q | (ACC_W'(in_data_i) << cnt_q);
      cnt_d = cnt_q + CNT_W'(DATA_OUT_BITS);
    end else if (out_valid_o) begin
      acc_d = acc_q >> c_w;
      cnt_d = cnt_q - c_w;
    end
  end

  // Accumulator state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/expand_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : expand_mask_gen
// Description : Dilithium ExpandMask engine. For each of l polynomials it
//               force-resets an external SHAKE256, absorbs rho'||(kappa+r),
//               squeezes 256*c bits and writes sign_extend(gamma1 - z) into
//               the y RAM at r*N + i.
//               Macro EXPAND_MASK_GAMMA17_EN: honour the mode input
//               (gamma1 = 2^17 or 2^19); otherwise gamma1 = 2^19 always.
// Revision    : 1.0
// ============================================================================
module expand_mask_gen
  import dilithium_pkg::*;
#(
  parameter int L_MAX         = 7,
  parameter int N             = 256,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int COEFF_W       = 24,
  parameter int ADDR_W        = $clog2(L_MAX*N)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mode,
  input  logic [2:0]                  l_cfg,
  input  logic [8*SEED_BYTES-1:0]     rho_prime,
  input  logic [15:0]                 kappa,
  output logic                        busy,
  output logic                        done,
  output logic                        we_y,
  output logic [ADDR_W-1:0]           addr_y,
  output logic [COEFF_W-1:0]          din_y,
  output logic                        absorb_next_poly,
  output logic [DATA_IN_BITS-1:0]     shake_data_in,
  output logic                        in_valid,
  output logic                        in_last,
  output logic [$clog2(DATA_IN_BITS):0] last_len,
  input  logic                        in_ready,
  input  logic [DATA_OUT_BITS-1:0]    shake_data_out,
  input  logic                        out_valid,
  output logic                        out_ready
);

  localparam int LL_W     = $clog2(DATA_IN_BITS) + 1;
  localparam int COEF_W   = $clog2(N);
  // The absorbed stream is 64 seed bytes then the 2 nonce bytes
  localparam int RHO_BITS = 8 * (SEED_BYTES - 2);

  emg_state_t            state_q, state_d;
  logic [2:0]            r_q, r_d;
  logic [2:0]            l_q, l_d;
  logic [15:0]           kappa_q, kappa_d;
  logic [RHO_BITS-1:0]   rho_q, rho_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [COEF_W-1:0]     coef_q, coef_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            l_clamp_w;
  logic [15:0]           nonce_w;
  logic                  unp_mode_w;
  logic                  unp_ready_w;
  logic                  unp_valid_w;
  logic [COEFF_W-1:0]    unp_data_w;

  // The top two bytes of the rho_prime port are not part of the stream
  logic unused_rho_hi;
  assign unused_rho_hi = ^rho_prime[8*SEED_BYTES-1:RHO_BITS];

`ifdef EXPAND_MASK_GAMMA17_EN
  logic mode_q, mode_d;
  assign unp_mode_w = mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign unp_mode_w  = 1'b1;
`endif

  assign l_clamp_w = ((l_cfg < 3'd4) || (int'(l_cfg) > L_MAX)) ? 3'(L_MAX) : l_cfg;
  assign nonce_w   = kappa_q + 16'(r_q);

  coeff_unpacker #(
    .DATA_OUT_BITS (DATA_OUT_BITS),
    .COEFF_W       (COEFF_W)
  ) u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (state_q == ST_SPONGE_RST),
    .mode_i      (unp_mode_w),
    .in_valid_i  ((state_q == ST_SQUEEZE) && out_valid),
    .in_ready_o  (unp_ready_w),
    .in_data_i   (shake_data_out),
    .out_valid_o (unp_valid_w),
    .out_data_o  (unp_data_w)
  );

  // Next-state and output decode; every output idles low
  always_comb begin
    state_d          = state_q;
    r_d              = r_q;
    l_d              = l_q;
    kappa_d          = kappa_q;
    rho_d            = rho_q;
    wcnt_d           = wcnt_q;
    coef_d           = coef_q;
    addr_d           = addr_q;
`ifdef EXPAND_MASK_GAMMA17_EN
    mode_d           = mode_q;
`endif
    busy             = 1'b0;
    done             = 1'b0;
    we_y             = 1'b0;
    addr_y           = '0;
    din_y            = '0;
    absorb_next_poly = 1'b0;
    shake_data_in    = '0;
    in_valid         = 1'b0;
    in_last          = 1'b0;
    last_len         = '0;
    out_ready        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SPONGE_RST;
          l_d     = l_clamp_w;
          kappa_d = kappa;
          rho_d   = rho_prime[RHO_BITS-1:0];
          r_d     = '0;
          addr_d  = '0;
`ifdef EXPAND_MASK_GAMMA17_EN
          mode_d  = mode;
`endif
        end
      end
      ST_SPONGE_RST: begin
        busy             = 1'b1;
        absorb_next_poly = 1'b1;
        wcnt_d           = '0;
        coef_d           = '0;
        state_d          = ST_ABSORB;
      end
      ST_ABSORB: begin
        busy     = 1'b1;
        in_valid = 1'b1;
        if (wcnt_q == 4'(ABSORB_WORDS - 1)) begin
          in_last       = 1'b1;
          last_len      = LL_W'(NONCE_BITS);
          shake_data_in = DATA_IN_BITS'(nonce_w);
        end else begin
          shake_data_in = rho_q[int'(wcnt_q[2:0]) * DATA_IN_BITS +: DATA_IN_BITS];
        end
        if (in_ready) begin
          if (wcnt_q == 4'(ABSORB_WORDS - 1)) begin
            state_d = ST_SQUEEZE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      ST_SQUEEZE: begin
        busy      = 1'b1;
        out_ready = unp_ready_w;
        we_y      = unp_valid_w;
        if (unp_valid_w) begin
          addr_y = addr_q;
          din_y  = unp_data_w;
          addr_d = addr_q + ADDR_W'(1);
          coef_d = coef_q + COEF_W'(1);
          if (coef_q == COEF_W'(N - 1)) begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        busy = 1'b1;
        r_d  = r_q + 3'd1;
        if (({1'b0, r_q} + 4'd1) == {1'b0, l_q}) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_SPONGE_RST;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and latched configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      l_q     <= '0;
      kappa_q <= '0;
      rho_q   <= '0;
      wcnt_q  <= '0;
      coef_q  <= '0;
      addr_q  <= '0;
`ifdef EXPAND_MASK_GAMMA17_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      l_q     <= l_d;
      kappa_q <= kappa_d;
      rho_q   <= rho_d;
      wcnt_q  <= wcnt_d;
      coef_q  <= coef_d;
      addr_q  <= addr_d;
`ifdef EXPAND_MASK_GAMMA17_EN
      mode_q  <= mode_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_expand_mask_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_expand_mask_gen
// Description : Directed self-checking bench for expand_mask_gen with a stub
//               SHAKE256 sponge (zero, all-ones or indexed-pattern stream).
// Revision    : 1.0
// ============================================================================
module tb_expand_mask_gen;

  localparam int ADDR_W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [2:0]   l_cfg = 3'd0;
  logic [527:0] rho_prime = '0;
  logic [15:0]  kappa = 16'd0;
  logic         busy, done, we_y;
  logic [ADDR_W-1:0] addr_y;
  logic [23:0]  din_y;
  logic         absorb_next_poly;
  logic [63:0]  shake_data_in;
  logic         in_valid, in_last;
  logic [6:0]   last_len;
  logic         in_ready = 1'b0;
  logic [63:0]  shake_data_out = '0;
  logic         out_valid = 1'b0;
  logic         out_ready;

  always #5 clk = ~clk;

  expand_mask_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mode             (mode),
    .l_cfg            (l_cfg),
    .rho_prime        (rho_prime),
    .kappa            (kappa),
    .busy             (busy),
    .done             (done),
    .we_y             (we_y),
    .addr_y           (addr_y),
    .din_y            (din_y),
    .absorb_next_poly (absorb_next_poly),
    .shake_data_in    (shake_data_in),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .last_len         (last_len),
    .in_ready         (in_ready),
    .shake_data_out   (shake_data_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Stub sponge knobs
  int pattern = 0;
  bit drop_valid = 1'b0;
  bit drop_ready = 1'b0;

  // Recorded observations
  int poly_idx = -1;
  int sq_cnt = 0;
  int ab_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [23:0] ram [0:2047];
  logic [63:0] absorbed [8][9];
  int          ab_words [8];
  int          sq_words [8];
  logic [6:0]  last_len_rec [8];

  function automatic logic [63:0] word_fn(int p, int w);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'(w) * 32'h9E3779B1 + 32'(p) * 32'h7F4A7C15;
    lo = {8'(p), 8'(w), 16'h5A00 ^ 16'(w * 37)};
    return {hi, lo};
  endfunction

  // Reference: coefficient j of polynomial p from a flat LSB-first bit stream
  function automatic logic [23:0] exp_coeff(int p, int j, int c, int gamma);
    logic [63:0] wd;
    int pos;
    int z;
    z = 0;
    for (int b = 0; b < c; b++) begin
      pos = j * c + b;
      wd  = word_fn(p, pos / 64);
      if (wd[pos % 64]) z += (1 << b);
    end
    return 24'(gamma - z);
  endfunction

  // Stub sponge and observer: observe at negedge, drive just after posedge
  initial begin : stub_monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        poly_idx = -1;
        sq_cnt   = 0;
        ab_cnt   = 0;
      end else begin
        if (start && !busy && !done) begin
          poly_idx = -1;
          wr_cnt   = 0;
          done_cnt = 0;
          for (int a = 0; a < 2048; a++) ram[a] = 24'h5A5A5A;
          for (int p = 0; p < 8; p++) begin
            ab_words[p] = 0;
            sq_words[p] = 0;
            last_len_rec[p] = 7'd0;
          end
        end
        if (absorb_next_poly) begin
          poly_idx++;
          sq_cnt = 0;
          ab_cnt = 0;
        end
        if (poly_idx >= 0 && poly_idx < 8) begin
          if (in_valid && in_ready) begin
            if (ab_cnt < 9) absorbed[poly_idx][ab_cnt] = shake_data_in;
            if (in_last) last_len_rec[poly_idx] = last_len;
            ab_cnt++;
            ab_words[poly_idx] = ab_cnt;
          end
          if (out_valid && out_ready) begin
            sq_cnt++;
            sq_words[poly_idx] = sq_cnt;
          end
        end
        if (we_y) begin
          ram[addr_y] = din_y;
          wr_cnt++;
          last_wr_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      in_ready  = drop_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_valid = drop_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      case (pattern)
        0:       shake_data_out = '0;
        1:       shake_data_out = '1;
        default: shake_data_out = word_fn(poly_idx, sq_cnt);
      endcase
    end
  end

  // Pulse start for one cycle; returns one cycle after the accepting edge
  task automatic kick(input logic m, input logic [2:0] l, input logic [15:0] k,
                      input logic [527:0] rho);
    @(posedge clk);
    #1;
    mode = m;
    l_cfg = l;
    kappa = k;
    rho_prime = rho;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (we_y !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we_y); end
    checks++; if ({addr_y, din_y} !== 35'd0) begin errors++; $display("FAIL reset_wport: got %h expected 0", {addr_y, din_y}); end
    checks++; if ({absorb_next_poly, in_valid, in_last, last_len, out_ready} !== 11'd0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 0", {absorb_next_poly, in_valid, in_last, last_len, out_ready});
    end
    checks++; if (shake_data_in !== 64'd0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", shake_data_in); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, we_y, din_y, in_valid, out_ready} !== 28'd0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", {busy, we_y, din_y, in_valid, out_ready});
    end
  endtask

  task automatic test_zero_stream;
    bit to;
    int bad;
    pattern = 0;
    kick(1'b1, 3'd4, 16'h0000, {16'h0, {8{64'hFEDCBA9876543210}}});
    checks++; if (absorb_next_poly !== 1'b1) begin errors++; $display("FAIL start_to_sponge_rst: got %b expected 1", absorb_next_poly); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    @(posedge clk);
    #1;
    checks++; if (absorb_next_poly !== 1'b0) begin errors++; $display("FAIL sponge_rst_width: got %b expected 0", absorb_next_poly); end
    checks++; if (shake_data_in !== 64'hFEDCBA9876543210 || in_valid !== 1'b1) begin
      errors++; $display("FAIL absorb_word0: got %h/%b expected fedcba9876543210/1", shake_data_in, in_valid);
    end
    wait_done(20000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %b expected 0", to); end
    checks++; if (wr_cnt !== 1024) begin errors++; $display("FAIL zero_writes: got %0d expected 1024", wr_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc - last_wr_cyc !== 2) begin errors++; $display("FAIL done_gap: got %0d expected 2", done_cyc - last_wr_cyc); end
    bad = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== 24'h080000) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_values: got %0d bad entries expected 0", bad); end
    checks++; if (ram[1024] !== 24'h5A5A5A) begin errors++; $display("FAIL zero_overrun: got %h expected 5a5a5a", ram[1024]); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (absorbed[p][8] !== 64'(p)) begin errors++; $display("FAIL zero_nonce p%0d: got %h expected %h", p, absorbed[p][8], 64'(p)); end
      checks++; if (ab_words[p] !== 9 || last_len_rec[p] !== 7'd16) begin
        errors++; $display("FAIL zero_absorb p%0d: got %0d words len %0d expected 9 len 16", p, ab_words[p], last_len_rec[p]);
      end
      checks++; if (sq_words[p] !== 80) begin errors++; $display("FAIL zero_squeeze p%0d: got %0d expected 80", p, sq_words[p]); end
    end
  endtask

  task automatic test_ones_stream;
    bit to;
    int bad;
    logic [23:0] exp_v;
    int exp_w;
`ifdef EXPAND_MASK_GAMMA17_EN
    exp_v = 24'hFE0001;
    exp_w = 72;
`else
    exp_v = 24'hF80001;
    exp_w = 80;
`endif
    pattern = 1;
    kick(1'b0, 3'd4, 16'h0000, '0);
    wait_done(20000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ones_timeout: got %b expected 0", to); end
    checks++; if (wr_cnt !== 1024) begin errors++; $display("FAIL ones_writes: got %0d expected 1024", wr_cnt); end
    bad = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== exp_v) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ones_values: got %0d bad, ram[0]=%h expected %h", bad, ram[0], exp_v); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (sq_words[p] !== exp_w) begin errors++; $display("FAIL ones_squeeze p%0d: got %0d expected %0d", p, sq_words[p], exp_w); end
    end
  endtask

  task automatic test_pattern_stalls;
    bit to;
    int bad;
    logic [15:0] exp_n [7];
    exp_n = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    pattern = 2;
    drop_valid = 1'b1;
    drop_ready = 1'b1;
    kick(1'b1, 3'd7, 16'hFFFE, {16'h0123, {8{64'h0123456789ABCDEF}}});
    wait_done(30000, to);
    drop_valid = 1'b0;
    drop_ready = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL pat_timeout: got %b expected 0", to); end
    checks++; if (wr_cnt !== 1792) begin errors++; $display("FAIL pat_writes: got %0d expected 1792", wr_cnt); end
    for (int p = 0; p < 7; p++) begin
      checks++; if (absorbed[p][8] !== {48'h0, exp_n[p]}) begin
        errors++; $display("FAIL pat_nonce p%0d: got %h expected %h", p, absorbed[p][8], exp_n[p]);
      end
    end
    checks++; if (absorbed[6][7] !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL pat_rho_word: got %h expected 0123456789abcdef", absorbed[6][7]); end
    bad = 0;
    for (int p = 0; p < 7; p++)
      for (int j = 0; j < 256; j++)
        if (ram[p * 256 + j] !== exp_coeff(p, j, 20, 524288)) begin
          bad++;
          if (bad <= 4) $display("FAIL pat_coeff addr %0d: got %h expected %h", p * 256 + j, ram[p * 256 + j], exp_coeff(p, j, 20, 524288));
        end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pat_values: got %0d bad entries expected 0", bad); end
  endtask

  task automatic test_start_while_busy;
    bit to;
    pattern = 0;
    kick(1'b1, 3'd3, 16'h0000, '0);
    for (int k = 0; k < 5; k++) begin
      repeat (100) @(posedge clk);
      #1;
      l_cfg = 3'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(20000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_timeout: got %b expected 0", to); end
    checks++; if (poly_idx + 1 !== 7) begin errors++; $display("FAIL clamp_polys: got %0d expected 7", poly_idx + 1); end
    checks++; if (wr_cnt !== 1792) begin errors++; $display("FAIL clamp_writes: got %0d expected 1792", wr_cnt); end
    checks++; if (ram[1791] !== 24'h080000) begin errors++; $display("FAIL clamp_last: got %h expected 080000", ram[1791]); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got %0d/%b expected 1/0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid;
    bit to;
    bit hit;
    int bad;
    pattern = 2;
    kick(1'b1, 3'd7, 16'h1000, '0);
    hit = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      #1;
      if (poly_idx == 2 && sq_cnt >= 20 && out_ready == 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_r2: got %b expected 1", hit); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, we_y, addr_y, din_y} !== 38'd0) begin errors++; $display("FAIL mid_rst_wport: got %h expected 0", {busy, done, we_y, addr_y, din_y}); end
    @(posedge clk);
    #1;
    checks++; if ({absorb_next_poly, in_valid, in_last, last_len, out_ready, shake_data_in} !== 75'd0) begin
      errors++; $display("FAIL mid_rst_sponge: got %h expected 0", {absorb_next_poly, in_valid, in_last, last_len, out_ready, shake_data_in});
    end
    rst_n = 1'b1;
    kick(1'b1, 3'd5, 16'h0100, '0);
    wait_done(20000, to);
    checks++; if (to !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL mid_rerun: got to=%b done=%0d expected 0/1", to, done_cnt); end
    checks++; if (absorbed[4][8] !== 64'h0104) begin errors++; $display("FAIL mid_nonce: got %h expected 0104", absorbed[4][8]); end
    bad = 0;
    for (int p = 0; p < 5; p++)
      for (int j = 0; j < 256; j++)
        if (ram[p * 256 + j] !== exp_coeff(p, j, 20, 524288)) bad++;
    checks++; if (bad !== 0 || wr_cnt !== 1280) begin errors++; $display("FAIL mid_values: got %0d bad, %0d writes expected 0, 1280", bad, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_ones_stream();
    test_pattern_stalls();
    test_start_while_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
